// File: rtl/inference_sequencer.sv
// inference_sequencer: launches each FNN layer in order and hands the argmax class downstream.
// Define FNN_SEQ_TIMEOUT_EN to bound each layer wait by TIMEOUT_CYC cycles and raise error.
module inference_sequencer #(
    parameter int NUM_LAYERS  = 3,
    parameter int CLASS_W     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [CLASS_W-1:0]    class_in,
    output logic [CLASS_W-1:0]    result_class,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  error
);
    localparam int IW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("inference_sequencer: unsupported parameter values");
    end

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, HOLD} state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [NUM_LAYERS-1:0] done_q, rise;
    logic                  pend, hit, last, tmo;

    assign rise = layer_done & ~done_q;
    // a rise during the launch cycle is remembered so WAIT still sees it
    assign hit  = rise[idx] | pend;
    assign last = idx == IW'(NUM_LAYERS - 1);

    assign busy         = state != IDLE;
    assign result_valid = state == HOLD;
    assign layer_start  = (state == LAUNCH) ? NUM_LAYERS'(1) << idx : '0;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE:    if (start) begin
                         state_nx = LAUNCH;
                         idx_nx   = '0;
                     end
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (hit) begin
                         state_nx = last ? CAPTURE : LAUNCH;
                         idx_nx   = last ? idx : idx + 1'b1;
                     end else if (tmo) begin
                         state_nx = IDLE;
                     end
            CAPTURE: state_nx = HOLD;
            HOLD:    if (result_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            done_q       <= '0;
            pend         <= 1'b0;
            result_class <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            done_q <= layer_done;
            pend   <= (state == LAUNCH) && rise[idx];
            if (state == CAPTURE) result_class <= class_in;
        end
    end

`ifdef FNN_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wcnt;
    logic          err_q;

    assign tmo   = (state == WAIT) && !hit && wcnt == CW'(TIMEOUT_CYC - 1);
    assign error = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            wcnt  <= (state == WAIT) ? wcnt + 1'b1 : '0;
            err_q <= tmo | (err_q & !(state == IDLE && start));
        end
    end
`else
    assign tmo   = 1'b0;
    assign error = 1'b0;
`endif
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: vector table plus hand sequences for stale done, async reset and timeout.
module tb_inference_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, start, result_ready, busy, result_valid, error;
    logic [2:0] layer_start, layer_done;
    logic [3:0] class_in, result_class;

    logic       man_mode = 1'b1;
    logic [2:0] man_done = '0, mdl_done = '0, prev_ls = '0;
    logic [3:0] man_cls = '0, mdl_cls = '0, cur_cls = '0;
    logic       last_rose = 1'b0, cap, rv_q = 1'b0;
    int         dly[3] = '{0, 0, 0};
    int         cnt[3] = '{0, 0, 0};
    int         exp_idx = 0;
    int         checks = 0, errors = 0;
    logic [3:0] sb[$];

    typedef struct {
        int         d0, d1, d2;
        logic [3:0] cls;
        int         rw;
        logic [3:0] exp_cls;
        int         lat;
    } vec_t;

    vec_t tbl[5];

    assign layer_done = man_mode ? man_done : mdl_done;
    assign class_in   = man_mode ? man_cls : mdl_cls;

    inference_sequencer #(.NUM_LAYERS(3), .CLASS_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .layer_start(layer_start), .layer_done(layer_done), .class_in(class_in),
        .result_class(result_class), .result_valid(result_valid),
        .result_ready(result_ready), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // layer responder: drops done on its launch pulse, raises it dly cycles later;
    // the output layer's class is only valid in the cycle after the last done rises
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt       = '{0, 0, 0};
            mdl_done  = '0;
            exp_idx   = 0;
            prev_ls   = '0;
            last_rose = 1'b0;
        end else begin
            logic [2:0] e;
            if (!busy) exp_idx = 0;
            if (layer_start != 3'b000) begin
                e = 3'b001 << exp_idx;
                chk("layer_start_order", layer_start, e);
                chk("layer_start_width", prev_ls, 0);
                exp_idx++;
            end
            prev_ls   = layer_start;
            cap       = last_rose;
            last_rose = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (layer_start[k]) begin
                    mdl_done[k] = 1'b0;
                    cnt[k]      = dly[k];
                end else if (cnt[k] != 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) begin
                        mdl_done[k] = 1'b1;
                        if (k == 2) last_rose = 1'b1;
                    end
                end
            end
            mdl_cls = cap ? cur_cls : ~cur_cls;
        end
    end

    // scoreboard: compare on each new result
    always @(negedge clk) begin
        if (result_valid && !rv_q) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got class %0h with no expected entry", result_class);
            end else begin
                logic [3:0] x;
                x = sb.pop_front();
                if (result_class !== x) begin
                    errors++;
                    $display("FAIL result_class: got %0h expected %0h", result_class, x);
                end
            end
        end
        rv_q = result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // caller is at a negedge with the DUT idle; returns at the negedge after the handshake
    task automatic run(input vec_t v);
        int n;
        chk("idle_busy", busy, 0);
        dly     = '{v.d0, v.d1, v.d2};
        cur_cls = v.cls;
        sb.push_back(v.exp_cls);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("busy_after_start", busy, 1);
        chk("error_after_start", error, 0);
        while (!result_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, v.lat);
        for (int i = 0; i < v.rw; i++) begin
            chk("hold_valid", result_valid, 1);
            chk("hold_class", result_class, v.exp_cls);
            start = (i == 2);
            @(negedge clk);
        end
        start        = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("post_handshake", {busy, result_valid}, 0);
    endtask

    initial begin
        int   n;
        logic seen_rv;
        tbl[0] = '{5, 7, 9, 4'd7, 0, 4'd7, 26};
        tbl[1] = '{1, 1, 1, 4'd3, 10, 4'd3, 8};
        tbl[2] = '{2, 3, 4, 4'd15, 1, 4'd15, 14};
        tbl[3] = '{1, 9, 2, 4'd0, 2, 4'd0, 17};
        tbl[4] = '{6, 1, 1, 4'd9, 0, 4'd9, 13};

        rst_n = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start        = 1'($urandom);
            result_ready = 1'($urandom);
            man_done     = 3'($urandom);
            man_cls      = 4'($urandom);
            chk("reset_outputs", {busy, layer_start, result_valid, result_class, error}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        result_ready = 1'b0;
        man_done = '0;
        man_mode = 1'b0;
        @(negedge clk);
        chk("after_reset", {busy, result_valid, error}, 0);

        foreach (tbl[i]) run(tbl[i]);

        // stale done on layer 0, then a layer-1 rise inside its launch cycle
        man_mode = 1'b1;
        man_cls  = 4'd9;
        man_done = 3'b001;
        @(negedge clk);
        sb.push_back(4'd9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("stale_launch0", layer_start, 3'b001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stale_no_progress", layer_start, 0);
        end
        man_done = 3'b000;
        repeat (2) @(negedge clk);
        man_done = 3'b001;
        @(negedge clk);
        chk("stale_launch1", layer_start, 3'b010);
        man_done = 3'b011;
        @(negedge clk);
        chk("launch_rise_wait", layer_start, 0);
        @(negedge clk);
        chk("launch_rise_launch2", layer_start, 3'b100);
        @(negedge clk);
        man_done = 3'b111;
        @(negedge clk);
        chk("capture_not_valid", result_valid, 0);
        @(negedge clk);
        chk("valid_two_after_rise", result_valid, 1);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        man_mode = 1'b0;
        chk("stale_done_idle", busy, 0);

        // async reset while waiting on layer 1
        dly     = '{3, 20, 3};
        cur_cls = 4'd5;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (layer_start != 3'b010 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_layer1", layer_start, 3'b010);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {busy, layer_start, result_valid, result_class, error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run('{2, 2, 2, 4'd11, 0, 4'd11, 11});

`ifdef FNN_SEQ_TIMEOUT_EN
        dly   = '{2, 0, 2};
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n       = 1;
        seen_rv = 1'b0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
            seen_rv |= result_valid;
        end
        chk("timeout_cycles", n, 21);
        chk("timeout_error", error, 1);
        chk("timeout_no_result", seen_rv, 0);
        run(tbl[1]);
`else
        seen_rv = 1'b0;
`endif

        chk("scoreboard_drained", sb.size(), 0);
        chk("final_state", {busy, result_valid, error, seen_rv}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
